// File: rtl/div_iter_seq.sv
// rtl/div_iter_seq.sv - restoring unsigned divider, one quotient bit per clock
// Valid/ready on both sides; a zero divisor bypasses CALC and reports div_zero.
module div_iter_seq #(
  parameter int size = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [size-1:0] div_a,
  input  logic [size-1:0] div_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [size-1:0] quotient,
  output logic [size-1:0] remainder,
  output logic            div_zero
);

  localparam int CW = (size > 1) ? $clog2(size) : 1;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t          r_state;
  state_t          w_next;
  logic [CW-1:0]   r_cnt;
  logic [size-1:0] r_dividend;
  logic [size-1:0] r_divisor;
  logic [size-1:0] r_rem;
  logic [size:0]   w_trial;
  logic            w_ge;
  logic [size-1:0] w_diff;
  logic [size-1:0] w_rem_next;
  logic [size-1:0] w_shift;

  // The trial value is size+1 bits so the compare never overflows; the
  // difference itself always fits in size bits because it is below the divisor.
  assign w_trial    = {r_rem, r_dividend[size-1]};
  assign w_ge       = (w_trial >= {1'b0, r_divisor});
  assign w_diff     = w_trial[size-1:0] - r_divisor;
  assign w_rem_next = w_ge ? w_diff : w_trial[size-1:0];
  // Quotient bits enter the dividend register as its MSBs leave.
  assign w_shift    = {r_dividend[size-2:0], w_ge};

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (in_valid) w_next = (div_b != '0) ? S_CALC : S_DONE;
      S_CALC: if (r_cnt == '0) w_next = S_DONE;
      S_DONE: if (out_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (r_state == S_IDLE);
    out_valid = (r_state == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt      <= '0;
      r_dividend <= '0;
      r_divisor  <= '0;
      r_rem      <= '0;
      quotient   <= '0;
      remainder  <= '0;
      div_zero   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            if (div_b != '0) begin
              r_dividend <= div_a;
              r_divisor  <= div_b;
              r_rem      <= '0;
              r_cnt      <= CW'(size - 1);
            end else begin
              quotient  <= '1;
              remainder <= div_a;
              div_zero  <= 1'b1;
            end
          end
        end
        S_CALC: begin
          r_dividend <= w_shift;
          r_rem      <= w_rem_next;
          if (r_cnt == '0) begin
            quotient  <= w_shift;
            remainder <= w_rem_next;
            div_zero  <= 1'b0;
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_iter_seq.sv
// tb/tb_div_iter_seq.sv - directed checks of div_iter_seq at size 4 and size 8
module tb_div_iter_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, in_ready, out_valid, out_ready, div_zero;
  logic [3:0] div_a, div_b, quotient, remainder;
  logic       in_valid8, in_ready8, out_valid8, out_ready8, div_zero8;
  logic [7:0] div_a8, div_b8, quotient8, remainder8;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  div_iter_seq #(.size(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .div_a(div_a), .div_b(div_b), .out_valid(out_valid), .out_ready(out_ready),
    .quotient(quotient), .remainder(remainder), .div_zero(div_zero)
  );

  div_iter_seq #(.size(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
    .div_a(div_a8), .div_b(div_b8), .out_valid(out_valid8), .out_ready(out_ready8),
    .quotient(quotient8), .remainder(remainder8), .div_zero(div_zero8)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_idle4(input string tag);
    chk({tag, "_in_ready"},  32'(in_ready),  32'd1);
    chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
  endtask

  task automatic div4(input string tag, input logic [3:0] a, input logic [3:0] b,
                      input logic [3:0] eq, input logic [3:0] er, input logic edz,
                      input int elat);
    int cyc;
    @(negedge clk);
    chk({tag, "_ready_at_accept"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1; div_a = a; div_b = b; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    cyc = 0;
    while (!out_valid && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    chk({tag, "_latency"},  32'(cyc),       32'(elat));
    chk({tag, "_quotient"}, 32'(quotient),  32'(eq));
    chk({tag, "_remainder"},32'(remainder), 32'(er));
    chk({tag, "_div_zero"}, 32'(div_zero),  32'(edz));
    @(negedge clk);
    chk_idle4({tag, "_after"});
  endtask

  initial begin
    int cyc;
    logic [7:0] a8, b8;
    int ea, eb;

    rst = 1'b1; in_valid = 1'b0; div_a = '0; div_b = '0; out_ready = 1'b0;
    in_valid8 = 1'b0; div_a8 = '0; div_b8 = '0; out_ready8 = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk_idle4("reset");
    chk("reset_quotient",  32'(quotient),  32'd0);
    chk("reset_remainder", 32'(remainder), 32'd0);
    chk("reset_div_zero",  32'(div_zero),  32'd0);

    div4("d13_3",  4'd13, 4'd3,  4'd4,  4'd1, 1'b0, 4);
    div4("d15_1",  4'd15, 4'd1,  4'd15, 4'd0, 1'b0, 4);
    div4("d3_9",   4'd3,  4'd9,  4'd0,  4'd3, 1'b0, 4);
    div4("d7_0",   4'd7,  4'd0,  4'd15, 4'd7, 1'b1, 0);
    div4("d15_15", 4'd15, 4'd15, 4'd1,  4'd0, 1'b0, 4);
    div4("d15_2",  4'd15, 4'd2,  4'd7,  4'd1, 1'b0, 4);
    div4("d0_5",   4'd0,  4'd5,  4'd0,  4'd0, 1'b0, 4);

    // Result held under backpressure while fresh operands are offered
    @(negedge clk);
    in_valid = 1'b1; div_a = 4'd10; div_b = 4'd4; out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    cyc = 0;
    while (!out_valid && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    chk("hold_latency", 32'(cyc), 32'd4);
    for (int i = 0; i < 4; i++) begin
      chk("hold_out_valid", 32'(out_valid), 32'd1);
      chk("hold_in_ready",  32'(in_ready),  32'd0);
      chk("hold_quotient",  32'(quotient),  32'd2);
      chk("hold_remainder", 32'(remainder), 32'd2);
      chk("hold_div_zero",  32'(div_zero),  32'd0);
      in_valid = (i < 3); div_a = 4'd1; div_b = 4'd1;
      if (i == 3) out_ready = 1'b1;
      if (i < 3) @(negedge clk);
    end
    @(negedge clk);
    chk_idle4("hold_release");
    chk("hold_release_quotient", 32'(quotient), 32'd2);
    @(negedge clk);
    chk_idle4("hold_no_merge");

    // Reset mid-CALC drops the in-flight result
    @(negedge clk);
    in_valid = 1'b1; div_a = 4'd13; div_b = 4'd3; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_idle4("midrst");
    chk("midrst_quotient",  32'(quotient),  32'd0);
    chk("midrst_remainder", 32'(remainder), 32'd0);
    chk("midrst_div_zero",  32'(div_zero),  32'd0);
    @(negedge clk);
    chk_idle4("midrst_dropped");
    div4("d9_2", 4'd9, 4'd2, 4'd4, 4'd1, 1'b0, 4);

    // size=8: in_valid held high across results, one result per accept
    for (int k = 0; k < 24; k++) begin
      a8 = 8'($urandom_range(0, 255));
      if (k % 6 == 0)      b8 = 8'd0;
      else if (k == 1)     b8 = 8'd1;
      else if (k == 2)     b8 = 8'd255;
      else if (k == 3)     b8 = a8 | 8'd1;
      else                 b8 = 8'($urandom_range(1, 255));
      ea = int'(a8); eb = int'(b8);
      cyc = 0;
      while (!in_ready8 && cyc < 50) begin
        @(negedge clk);
        cyc++;
      end
      chk("s8_in_ready", 32'(in_ready8), 32'd1);
      in_valid8 = 1'b1; div_a8 = a8; div_b8 = b8;
      @(negedge clk);
      cyc = 0;
      while (!out_valid8 && cyc < 50) begin
        @(negedge clk);
        cyc++;
      end
      chk("s8_latency",   32'(cyc),        (eb == 0) ? 32'd0 : 32'd8);
      chk("s8_quotient",  32'(quotient8),  (eb == 0) ? 32'd255 : 32'(ea / eb));
      chk("s8_remainder", 32'(remainder8), (eb == 0) ? 32'(ea) : 32'(ea % eb));
      chk("s8_div_zero",  32'(div_zero8),  (eb == 0) ? 32'd1 : 32'd0);
      @(negedge clk);
      chk("s8_single_result", 32'(out_valid8), 32'd0);
    end
    in_valid8 = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
